// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus controller.
package cart_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  typedef enum logic {
    READ,
    WRITE
  } op_t;

  localparam logic [15:0] CART_RAM_LO = 16'hA000;
  localparam logic [15:0] CART_RAM_HI = 16'hFDFF;

  function automatic logic in_ram_window(input logic [15:0] addr);
    return (addr >= CART_RAM_LO) && (addr <= CART_RAM_HI);
  endfunction

endpackage

// File: rtl/cart_phi_gen.sv
// Free-running cart PHI clock: clk_8m / PHI_DIV, low for the first half of each period.
module cart_phi_gen #(
  parameter int unsigned PHI_DIV = 8
) (
  input  logic clk_8m,
  input  logic rst,
  output logic cart_phi
);

  localparam int unsigned CW = $clog2(PHI_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  always_comb begin
    cnt_n = (cnt == CW'(PHI_DIV - 1)) ? '0 : cnt + CW'(1);
  end

  // Output registered from the next count so cart_phi tracks cnt without a comb path.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      cnt      <= '0;
      cart_phi <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      cart_phi <= (cnt_n >= CW'(PHI_DIV / 2));
    end
  end

endmodule

// File: rtl/cart_bus_ctrl.sv
// Turns one-cycle ROM read/write requests into timed Game Boy cartridge bus cycles.
module cart_bus_ctrl
  import cart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned PHI_DIV    = 8
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic [15:0] rom_addr,
  input  logic        rom_rd,
  input  logic        rom_wr,
  input  logic [7:0]  rom_wdata,
  output logic [7:0]  rom_data,
  output logic        rom_bsy,
  output logic [15:0] cart_a,
  input  logic [7:0]  cart_d_in,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n,
  output logic        cart_phi
);

  localparam int unsigned MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  state_t        state, state_n;
  op_t           op, op_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   cart_a_n;
  logic [7:0]    cart_d_out_n;
  logic          cart_d_oe_n;
  logic [7:0]    rom_data_n;

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state      <= IDLE;
      op         <= READ;
      cnt        <= '0;
      cart_a     <= '0;
      cart_d_out <= '0;
      cart_d_oe  <= 1'b0;
      rom_data   <= '0;
    end else begin
      state      <= state_n;
      op         <= op_n;
      cnt        <= cnt_n;
      cart_a     <= cart_a_n;
      cart_d_out <= cart_d_out_n;
      cart_d_oe  <= cart_d_oe_n;
      rom_data   <= rom_data_n;
    end
  end

  always_comb begin
    state_n      = state;
    op_n         = op;
    cnt_n        = cnt;
    cart_a_n     = cart_a;
    cart_d_out_n = cart_d_out;
    cart_d_oe_n  = cart_d_oe;
    rom_data_n   = rom_data;
    case (state)
      IDLE: begin
        // Read has priority; a simultaneous write is dropped.
        if (rom_rd || rom_wr) begin
          cart_a_n = rom_addr;
          if (rom_rd) begin
            op_n = READ;
          end else begin
            op_n         = WRITE;
            cart_d_out_n = rom_wdata;
            cart_d_oe_n  = 1'b1;
          end
          if (SETUP_CYC == 0) begin
            state_n = STROBE;
            cnt_n   = STROBE_LD;
          end else begin
            state_n = SETUP;
            cnt_n   = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = STROBE_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          if (op == READ) rom_data_n = cart_d_in;
          if (HOLD_CYC == 0) begin
            state_n     = IDLE;
            cart_d_oe_n = 1'b0;
          end else begin
            state_n = HOLD;
            cnt_n   = HOLD_LD;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n     = IDLE;
          cart_d_oe_n = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rom_bsy   = (state != IDLE) || rom_rd || rom_wr;
    cart_rd_n = !((state == STROBE) && (op == READ));
    cart_wr_n = !((state == STROBE) && (op == WRITE));
    cart_cs_n = !((state != IDLE) && in_ram_window(cart_a));
  end

  cart_phi_gen #(
    .PHI_DIV(PHI_DIV)
  ) u_phi (
    .clk_8m  (clk_8m),
    .rst     (rst),
    .cart_phi(cart_phi)
  );

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Bench for cart_bus_ctrl: per-cycle transaction-timeline model, directed sequences, vector table, random traffic.
`timescale 1ns/1ps
module tb_cart_bus_ctrl;

  localparam int S   = 1;
  localparam int B   = 3;
  localparam int H   = 1;
  localparam int DIV = 8;
  localparam int L   = S + B + H;

  logic        clk_8m = 1'b0;
  logic        rst, rom_rd, rom_wr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_wdata;
  logic [7:0]  rom_data;
  logic        rom_bsy;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_in, cart_d_out;
  logic        cart_d_oe, cart_rd_n, cart_wr_n, cart_cs_n, cart_phi;

  logic [7:0] mem [0:65535];
  logic [7:0] logo [48] = '{
    8'hCE, 8'hED, 8'h66, 8'h66, 8'hCC, 8'h0D, 8'h00, 8'h0B, 8'h03, 8'h73, 8'h00, 8'h83,
    8'h00, 8'h0C, 8'h00, 8'h0D, 8'h00, 8'h08, 8'h11, 8'h1F, 8'h88, 8'h89, 8'h00, 8'h0E,
    8'hDC, 8'hCC, 8'h6E, 8'hE6, 8'hDD, 8'hDD, 8'hD9, 8'h99, 8'hBB, 8'hBB, 8'h67, 8'h63,
    8'h6E, 8'h0E, 8'hEC, 8'hCC, 8'hDD, 8'hDC, 8'h99, 8'h9F, 8'hBB, 8'hB9, 8'h33, 8'h3E};

  assign cart_d_in = mem[cart_a];

  cart_bus_ctrl #(
    .SETUP_CYC (S),
    .STROBE_CYC(B),
    .HOLD_CYC  (H),
    .PHI_DIV   (DIV)
  ) dut (
    .clk_8m    (clk_8m),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_rd    (rom_rd),
    .rom_wr    (rom_wr),
    .rom_wdata (rom_wdata),
    .rom_data  (rom_data),
    .rom_bsy   (rom_bsy),
    .cart_a    (cart_a),
    .cart_d_in (cart_d_in),
    .cart_d_out(cart_d_out),
    .cart_d_oe (cart_d_oe),
    .cart_rd_n (cart_rd_n),
    .cart_wr_n (cart_wr_n),
    .cart_cs_n (cart_cs_n),
    .cart_phi  (cart_phi)
  );

  always #5 clk_8m = ~clk_8m;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // Reference model: one accepted transaction described by its cycle offset k.
  bit          m_act;
  int          m_k;
  bit          m_wr;
  logic [15:0] m_a;
  logic [7:0]  m_dout, m_data;
  int          m_phi;

  // Values sampled in the most recent tick.
  logic        o_bsy, o_rdl, o_wrl, o_csl, o_oe, o_phi;
  logic [15:0] o_a_now;
  logic [7:0]  o_data_now, o_dout_now;
  logic [6:0]  v_bsy, v_rdl, v_wrl, v_csl, v_oe;
  logic [15:0] o_a [7];
  logic [7:0]  o_data [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'hA000) && (a <= 16'hFDFF);
  endfunction

  task automatic model_compare();
    bit strobe;
    strobe = m_act && (m_k > S) && (m_k <= S + B);
    chk("m_bsy",   rom_bsy,    m_act || rom_rd || rom_wr);
    chk("m_rd_n",  cart_rd_n,  !(strobe && !m_wr));
    chk("m_wr_n",  cart_wr_n,  !(strobe && m_wr));
    chk("m_cs_n",  cart_cs_n,  !(m_act && in_win(m_a)));
    chk("m_oe",    cart_d_oe,  m_act && m_wr);
    chk("m_a",     cart_a,     m_a);
    chk("m_dout",  cart_d_out, m_dout);
    chk("m_data",  rom_data,   m_data);
    chk("m_phi",   cart_phi,   (m_phi >= DIV / 2));
  endtask

  task automatic model_update();
    if (rst) begin
      m_act = 0; m_k = 0; m_wr = 0;
      m_a = '0; m_dout = '0; m_data = '0; m_phi = 0;
      return;
    end
    m_phi = (m_phi + 1) % DIV;
    if (m_act) begin
      if (!m_wr && m_k == S + B) m_data = mem[m_a];
      m_k++;
      if (m_k > L) m_act = 0;
    end else if (rom_rd || rom_wr) begin
      m_act = 1;
      m_k   = 1;
      m_wr  = !rom_rd;
      m_a   = rom_addr;
      if (!rom_rd) m_dout = rom_wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk_8m);
    if (chk_en) model_compare();
    o_bsy = rom_bsy; o_rdl = !cart_rd_n; o_wrl = !cart_wr_n; o_csl = !cart_cs_n;
    o_oe = cart_d_oe; o_phi = cart_phi; o_a_now = cart_a;
    o_data_now = rom_data; o_dout_now = cart_d_out;
    model_update();
    @(posedge clk_8m);
    #1;
    cyc++;
  endtask

  // Issue one request at offset 0 and record offsets 0..6.
  task automatic run_req(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [7:0] wd, input int rd2_at, input int rst_at);
    for (int i = 0; i < 7; i++) begin
      rom_rd    = (i == 0) ? rd : (i == rd2_at);
      rom_wr    = (i == 0) ? wr : 1'b0;
      rom_addr  = (i == rd2_at) ? 16'h3000 : a;
      rom_wdata = wd;
      rst       = (i == rst_at);
      tick();
      v_bsy[i] = o_bsy; v_rdl[i] = o_rdl; v_wrl[i] = o_wrl;
      v_csl[i] = o_csl; v_oe[i] = o_oe;
      o_a[i] = o_a_now; o_data[i] = o_data_now;
    end
    rom_rd = 0; rom_wr = 0; rst = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  wd;
    logic        cs_exp;
    logic [7:0]  data_exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] ta;
    int busy;
    int rises;
    logic prev_phi;

    for (int i = 0; i < 65536; i++) begin
      ta = i[15:0];
      mem[i] = ta[7:0] ^ ta[15:8] ^ 8'h5A;
    end
    for (int i = 0; i < 48; i++) mem[16'h0104 + i] = logo[i];

    tbl[0] = '{1'b0, 16'h0104, 8'h00, 1'b0, 8'hCE};
    tbl[1] = '{1'b0, 16'h9FFF, 8'h00, 1'b0, 8'h3A};
    tbl[2] = '{1'b0, 16'hA000, 8'h00, 1'b1, 8'hFA};
    tbl[3] = '{1'b0, 16'hFDFF, 8'h00, 1'b1, 8'h58};
    tbl[4] = '{1'b0, 16'hFE00, 8'h00, 1'b0, 8'hA4};
    tbl[5] = '{1'b1, 16'hA000, 8'h0A, 1'b1, 8'hA4};
    tbl[6] = '{1'b1, 16'h2000, 8'h55, 1'b0, 8'hA4};

    rst = 1; rom_rd = 0; rom_wr = 0; rom_addr = '0; rom_wdata = '0;
    m_act = 0; m_k = 0; m_wr = 0; m_a = '0; m_dout = '0; m_data = '0; m_phi = 0;
    @(posedge clk_8m); #1;
    tick();
    tick();
    rst = 0;
    chk_en = 1;

    // Reset state
    tick();
    chk("rst_data", o_data_now, 8'h00);
    chk("rst_a",    o_a_now,    16'h0000);
    chk("rst_dout", o_dout_now, 8'h00);
    chk("rst_oe",   o_oe,  1'b0);
    chk("rst_rdl",  o_rdl, 1'b0);
    chk("rst_wrl",  o_wrl, 1'b0);
    chk("rst_csl",  o_csl, 1'b0);
    chk("rst_bsy",  o_bsy, 1'b0);

    // Single read at 0x0104
    run_req(1, 0, 16'h0104, 8'h00, -1, -1);
    chk("rd_bsy",  v_bsy, 7'h3F);
    chk("rd_rdl",  v_rdl, 7'h1C);
    chk("rd_csl",  v_csl, 7'h00);
    chk("rd_data", o_data[6], 8'hCE);

    // Write to external RAM
    run_req(0, 1, 16'hA000, 8'h0A, -1, -1);
    chk("wr_oe",   v_oe,  7'h3E);
    chk("wr_wrl",  v_wrl, 7'h1C);
    chk("wr_rdl",  v_rdl, 7'h00);
    chk("wr_csl",  v_csl, 7'h3E);
    chk("wr_dout", o_dout_now, 8'h0A);
    chk("wr_data", o_data[6], 8'hCE);

    // Read and write together, then a stray read while busy
    run_req(1, 1, 16'h2000, 8'hEE, 3, -1);
    chk("col_wrl",  v_wrl, 7'h00);
    chk("col_rdl",  v_rdl, 7'h1C);
    chk("col_a4",   o_a[4], 16'h2000);
    chk("col_a6",   o_a[6], 16'h2000);
    chk("col_data", o_data[6], 8'h7A);

    // Sequential logo reads, next request the cycle after rom_bsy falls
    for (int n = 0; n < 48; n++) begin
      rom_rd = 1; rom_addr = 16'h0104 + 16'(n);
      tick();
      rom_rd = 0;
      busy = 1;
      for (int j = 0; j < 20; j++) begin
        tick();
        if (!o_bsy) break;
        busy++;
      end
      chk("seq_busy", busy, 6);
      chk("seq_data", o_data_now, logo[n]);
    end

    // Vector table
    for (int v = 0; v < 7; v++) begin
      run_req(!tbl[v].wr, tbl[v].wr, tbl[v].a, tbl[v].wd, -1, -1);
      chk("tbl_cs",   |v_csl, tbl[v].cs_exp);
      chk("tbl_bsy",  v_bsy, 7'h3F);
      chk("tbl_data", o_data[6], tbl[v].data_exp);
    end

    // Reset during STROBE
    run_req(1, 0, 16'h0150, 8'h00, -1, 3);
    chk("rstm_bsy",  v_bsy, 7'h0F);
    chk("rstm_rdl",  v_rdl, 7'h0C);
    chk("rstm_oe",   v_oe,  7'h00);
    chk("rstm_data", o_data[4], 8'h00);
    chk("rstm_a",    o_a[4], 16'h0000);

    // PHI phase over 64 cycles from reset with accesses interleaved
    rst = 1;
    tick();
    rst = 0;
    rises = 0;
    prev_phi = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rom_rd = (c % 10 == 2);
      rom_wr = (c % 10 == 6) && (c > 10);
      rom_addr = 16'(c * 16'h0531);
      rom_wdata = 8'(c);
      tick();
      chk("phi_phase", o_phi, ((c % DIV) >= DIV / 2));
      if (o_phi && !prev_phi) rises++;
      prev_phi = o_phi;
    end
    rom_rd = 0; rom_wr = 0;
    chk("phi_rises", rises, 8);

    // Random traffic against the model
    for (int r = 0; r < 600; r++) begin
      rst    = ($urandom_range(0, 79) == 0);
      rom_rd = ($urandom_range(0, 3) == 0);
      rom_wr = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0: rom_addr = 16'h9FFF;
        1: rom_addr = 16'hA000;
        2: rom_addr = 16'hFDFF;
        3: rom_addr = 16'hFE00;
        default: rom_addr = 16'($urandom);
      endcase
      rom_wdata = 8'($urandom);
      tick();
    end
    rst = 0; rom_rd = 0; rom_wr = 0;
    for (int r = 0; r < 8; r++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
